// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the burst-refill write-through cache controller.
package cache_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READ  = 4'd1,
    S_RMISS = 4'd2,
    S_RMEM  = 4'd3,
    S_RDATA = 4'd4,
    S_WRITE = 4'd5,
    S_WHIT  = 4'd6,
    S_WMISS = 4'd7,
    S_WMEM  = 4'd8,
    S_WDATA = 4'd9
  } state_t;

  localparam int DEF_WAIT_CYCLES = 4;
  localparam int DEF_BEATS       = 4;

  // Beat index width; a one-word line still exposes a 1-bit Beat.
  function automatic int beat_w(input int beats);
    return (beats > 2) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/wait_ctr_p.sv
// Loadable down-counter that times one memory access; holds at zero.
module wait_ctr_p #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (ld) begin
      r_cnt <= ld_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/cache_ctrl_burst.sv
// Direct-mapped write-through cache controller with multi-beat refill,
// optional write-allocate and saturating hit/miss counters.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES,
  parameter int BEATS          = DEF_BEATS,
  parameter int WRITE_ALLOCATE = 0,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Strobe,
  input  logic                        DRW,
  input  logic                        M,
  input  logic                        V,
  output logic                        DReady,
  output logic                        W,
  output logic                        MStrobe,
  output logic                        MRW,
  output logic                        RSel,
  output logic                        WSel,
  output logic [beat_w(BEATS)-1:0]    Beat,
  output logic                        Busy,
  output logic [CNT_W-1:0]            HitCnt,
  output logic [CNT_W-1:0]            MissCnt
);

  localparam int             BW        = beat_w(BEATS);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("cache_ctrl_burst: WAIT_CYCLES must be 1..255");
  end
  if (BEATS < 1 || BEATS > 16 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("cache_ctrl_burst: BEATS must be a power of 2 in 1..16");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_beat;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_drw;
  logic             r_wmiss;
  logic             w_hit;
  logic             w_ld;
  logic             w_zero;
  logic             w_hit_inc;
  logic             w_miss_inc;
  logic             w_beat_clr;
  logic             w_beat_inc;

  assign w_hit = M & V;

  wait_ctr_p #(.W(8)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .ld     (w_ld),
    .ld_val (8'(WAIT_CYCLES - 1)),
    .zero   (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    DReady     = 1'b0;
    W          = 1'b0;
    MStrobe    = 1'b0;
    MRW        = 1'b0;
    RSel       = 1'b0;
    WSel       = 1'b0;
    Busy       = 1'b0;
    w_ld       = 1'b0;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;
    w_beat_clr = 1'b0;
    w_beat_inc = 1'b0;
    case (r_state)
      S_IDLE: if (Strobe) w_next = DRW ? S_WRITE : S_READ;
      S_READ: begin
        Busy = 1'b1;
        if (w_hit) begin
          DReady    = 1'b1;
          w_hit_inc = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_miss_inc = 1'b1;
          w_beat_clr = 1'b1;
          w_next     = S_RMISS;
        end
      end
      S_RMISS: begin
        Busy    = 1'b1;
        MStrobe = 1'b1;
        w_ld    = 1'b1;
        w_next  = S_RMEM;
      end
      S_RMEM: begin
        Busy = 1'b1;
        if (w_zero) w_next = S_RDATA;
      end
      S_RDATA: begin
        Busy = 1'b1;
        W    = 1'b1;
        WSel = 1'b1;
        RSel = 1'b1;
        if (r_beat == BEAT_LAST) begin
          DReady     = 1'b1;
          w_beat_clr = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_beat_inc = 1'b1;
          w_next     = S_RMISS;
        end
      end
      S_WRITE: begin
        Busy = 1'b1;
        if (w_hit) begin
          w_hit_inc = 1'b1;
          w_next    = S_WHIT;
        end else begin
          w_miss_inc = 1'b1;
          w_next     = S_WMISS;
        end
      end
      S_WHIT: begin
        Busy    = 1'b1;
        W       = 1'b1;
        MStrobe = 1'b1;
        MRW     = 1'b1;
        w_ld    = 1'b1;
        w_next  = S_WMEM;
      end
      S_WMISS: begin
        Busy    = 1'b1;
        MStrobe = 1'b1;
        MRW     = 1'b1;
        w_ld    = 1'b1;
        w_next  = S_WMEM;
      end
      S_WMEM: begin
        Busy = 1'b1;
        MRW  = 1'b1;
        if (w_zero) w_next = S_WDATA;
      end
      S_WDATA: begin
        Busy = 1'b1;
        MRW  = 1'b1;
        // Allocating write miss hands over to the refill; DReady comes from its last beat.
        if (WRITE_ALLOCATE != 0 && r_drw && r_wmiss) begin
          w_beat_clr = 1'b1;
          w_next     = S_RMISS;
        end else begin
          DReady = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_drw      <= 1'b0;
      r_wmiss    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && Strobe) r_drw <= DRW;
      if (r_state == S_WRITE) r_wmiss <= ~w_hit;
      if (w_beat_clr) begin
        r_beat <= '0;
      end else if (w_beat_inc) begin
        r_beat <= r_beat + BW'(1);
      end
      if (w_hit_inc)  r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (w_miss_inc) r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign Beat    = r_beat;
  assign HitCnt  = r_hit_cnt;
  assign MissCnt = r_miss_cnt;

endmodule
